// File: rtl/elevator_pkg.sv
// Shared floor encoding and scheduler state type for the elevator request scheduler.
// Floors are numbered 1..NUM_FLOORS; encoding 0 and codes above NUM_FLOORS are invalid.
package elevator_pkg;

  localparam int NUM_FLOORS = 8;
  localparam int FLOOR_W    = 4;

  localparam logic [FLOOR_W-1:0] FLOOR_MIN = 4'd1;
  localparam logic [FLOOR_W-1:0] FLOOR_MAX = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_SERVING,
    ST_EMERG
  } state_t;

endpackage

// File: rtl/scan_select.sv
// SCAN target selector: purely combinational, zero latency, no flow control.
// Prefers the nearest pending floor ahead of the sweep (current floor included), else reverses.
module scan_select #(
  parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W    = elevator_pkg::FLOOR_W
) (
  input  logic [NUM_FLOORS:1] pending,
  input  logic [FLOOR_W-1:0]  car_floor,
  input  logic                sweep_up,
  output logic                sel_valid,
  output logic [FLOOR_W-1:0]  sel_floor,
  output logic                sel_dir
);
  import elevator_pkg::*;

  logic               ahead_vld;
  logic               behind_vld;
  logic [FLOOR_W-1:0] ahead_floor;
  logic [FLOOR_W-1:0] behind_floor;

  always_comb begin
    ahead_vld    = 1'b0;
    behind_vld   = 1'b0;
    ahead_floor  = FLOOR_W'(FLOOR_MIN);
    behind_floor = FLOOR_W'(FLOOR_MIN);
    if (sweep_up) begin
      // Last hit wins: the down-counting scan leaves the lowest floor at/above the car.
      for (int f = NUM_FLOORS; f >= 1; f--) begin
        if (pending[f] && (FLOOR_W'(f) >= car_floor)) begin
          ahead_vld   = 1'b1;
          ahead_floor = FLOOR_W'(f);
        end
      end
      for (int f = 1; f <= NUM_FLOORS; f++) begin
        if (pending[f] && (FLOOR_W'(f) < car_floor)) begin
          behind_vld   = 1'b1;
          behind_floor = FLOOR_W'(f);
        end
      end
    end else begin
      for (int f = 1; f <= NUM_FLOORS; f++) begin
        if (pending[f] && (FLOOR_W'(f) <= car_floor)) begin
          ahead_vld   = 1'b1;
          ahead_floor = FLOOR_W'(f);
        end
      end
      for (int f = NUM_FLOORS; f >= 1; f--) begin
        if (pending[f] && (FLOOR_W'(f) > car_floor)) begin
          behind_vld   = 1'b1;
          behind_floor = FLOOR_W'(f);
        end
      end
    end
    sel_valid = ahead_vld | behind_vld;
    sel_floor = ahead_vld ? ahead_floor : behind_floor;
    sel_dir   = ahead_vld ? sweep_up : ~sweep_up;
  end

endmodule

// File: rtl/elevator_request_scheduler.sv
// Collects floor calls and dispatches one SCAN-ordered target at a time; call-to-valid is 2 cycles.
// target_floor is held while target_ready is low; an emergency drops all calls and any dispatch.
module elevator_request_scheduler #(
  parameter int NUM_FLOORS     = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W        = elevator_pkg::FLOOR_W,
  parameter int TIMEOUT_CYCLES = 1 << 29
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [NUM_FLOORS:1] call_floor,
  input  logic                emergency_button,
  input  logic [FLOOR_W-1:0]  car_floor,
  input  logic                arrived,
  input  logic                target_ready,
  output logic [FLOOR_W-1:0]  target_floor,
  output logic                target_valid,
  output logic [NUM_FLOORS:1] pending,
  output logic                sweep_up,
  output logic                emergency_active,
  output logic                fault
);
  import elevator_pkg::*;

  localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t              state;
  state_t              state_nxt;
  logic                car_ok;
  logic [NUM_FLOORS:1] clear_mask;
  logic                sel_valid;
  logic [FLOOR_W-1:0]  sel_floor;
  logic                sel_dir;
  logic [CNT_W-1:0]    serve_cnt;
  logic                dispatch_go;
  logic                timeout_hit;

  assign car_ok = (car_floor >= FLOOR_W'(FLOOR_MIN)) && (car_floor <= FLOOR_W'(NUM_FLOORS));

  // An arrival reported at an invalid floor must not clear anything.
  always_comb begin
    clear_mask = '0;
    for (int f = 1; f <= NUM_FLOORS; f++) begin
      if (arrived && car_ok && (car_floor == FLOOR_W'(f))) begin
        clear_mask[f] = 1'b1;
      end
    end
  end

  scan_select #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_scan_select (
    .pending   (pending),
    .car_floor (car_floor),
    .sweep_up  (sweep_up),
    .sel_valid (sel_valid),
    .sel_floor (sel_floor),
    .sel_dir   (sel_dir)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    dispatch_go = 1'b0;
    timeout_hit = 1'b0;
    if (emergency_button) begin
      state_nxt = ST_EMERG;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel_valid && car_ok) begin
            state_nxt   = ST_DISPATCH;
            dispatch_go = 1'b1;
          end
        end
        ST_DISPATCH: begin
          if (target_ready) begin
            state_nxt = ST_SERVING;
          end
        end
        ST_SERVING: begin
          if (arrived && (car_floor == target_floor)) begin
            state_nxt = ST_IDLE;
          end else if (serve_cnt == CNT_LAST) begin
            // Abandon the dispatch but keep its call pending for a later retry.
            state_nxt   = ST_IDLE;
            timeout_hit = 1'b1;
          end
        end
        ST_EMERG: begin
          state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      pending          <= '0;
      target_floor     <= FLOOR_W'(FLOOR_MIN);
      target_valid     <= 1'b0;
      sweep_up         <= 1'b1;
      emergency_active <= 1'b0;
      fault            <= 1'b0;
      serve_cnt        <= '0;
    end else begin
      if (emergency_button || (state == ST_EMERG)) begin
        pending <= '0;
      end else begin
        pending <= (pending | call_floor) & ~clear_mask;
      end

      target_valid     <= (state_nxt == ST_DISPATCH);
      emergency_active <= (state_nxt == ST_EMERG);

      if (dispatch_go) begin
        target_floor <= sel_floor;
        sweep_up     <= sel_dir;
      end

      if (timeout_hit || !car_ok) begin
        fault <= 1'b1;
      end

      // Held at zero outside SERVING so every new dispatch starts a fresh count.
      if (state != ST_SERVING) begin
        serve_cnt <= '0;
      end else if (serve_cnt != {CNT_W{1'b1}}) begin
        serve_cnt <= serve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Bench for elevator_request_scheduler: directed scenarios plus randomized car traffic,
// all checked every cycle against a behavioural SCAN model.
module tb_elevator_request_scheduler;

  localparam int TMO = 16;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic [8:1] call_floor = '0;
  logic       emergency_button = 1'b0;
  logic [3:0] car_floor = 4'd1;
  logic       arrived = 1'b0;
  logic       target_ready = 1'b0;
  logic [3:0] target_floor;
  logic       target_valid;
  logic [8:1] pending;
  logic       sweep_up;
  logic       emergency_active;
  logic       fault;

  always #5 CLK = ~CLK;

  elevator_request_scheduler #(
    .NUM_FLOORS     (8),
    .FLOOR_W        (4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK              (CLK),
    .reset            (reset),
    .call_floor       (call_floor),
    .emergency_button (emergency_button),
    .car_floor        (car_floor),
    .arrived          (arrived),
    .target_ready     (target_ready),
    .target_floor     (target_floor),
    .target_valid     (target_valid),
    .pending          (pending),
    .sweep_up         (sweep_up),
    .emergency_active (emergency_active),
    .fault            (fault)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: outstanding offer, car en route, emergency, calls, and fault.
  bit [8:1] m_pend;
  int       m_tf;
  bit       m_offer;
  bit       m_enroute;
  int       m_served;
  bit       m_up;
  bit       m_emerg;
  bit       m_fault;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_tf = 1; m_offer = 0; m_enroute = 0; m_served = 0;
    m_up = 1; m_emerg = 0; m_fault = 0;
  endtask

  // SCAN rule: pending floors sorted ascending, then pick ahead-of-sweep or reverse.
  function automatic void pick(input bit [8:1] p, input int car, input bit up,
                               output bit ok, output int fl, output bit dir);
    int calls[$];
    ok = 0; fl = 0; dir = up;
    for (int i = 1; i <= 8; i++) if (p[i]) calls.push_back(i);
    if (up) begin
      foreach (calls[k]) if (!ok && calls[k] >= car) begin ok = 1; fl = calls[k]; end
      if (!ok) foreach (calls[k]) if (calls[k] < car) begin ok = 1; fl = calls[k]; dir = 0; end
    end else begin
      foreach (calls[k]) if (calls[k] <= car) begin ok = 1; fl = calls[k]; end
      if (!ok) foreach (calls[k]) if (!ok && calls[k] > car) begin ok = 1; fl = calls[k]; dir = 1; end
    end
  endfunction

  task automatic compare_all();
    check("pending", pending, m_pend);
    check("target_valid", target_valid, m_offer);
    check("target_floor", target_floor, m_tf);
    check("sweep_up", sweep_up, m_up);
    check("emergency_active", emergency_active, m_emerg);
    check("fault", fault, m_fault);
  endtask

  task automatic step(input bit [8:1] c, input bit e, input int cf, input bit a, input bit r);
    bit [8:1] n_pend, clr;
    int n_tf, n_served, fl;
    bit n_offer, n_enroute, n_up, n_emerg, n_fault, ok, dir, car_ok;
    @(negedge CLK);
    call_floor = c; emergency_button = e; car_floor = 4'(cf); arrived = a; target_ready = r;
    car_ok = (cf >= 1) && (cf <= 8);
    n_pend = m_pend; n_tf = m_tf; n_offer = m_offer; n_enroute = m_enroute;
    n_served = m_served; n_up = m_up; n_emerg = m_emerg; n_fault = m_fault;
    clr = '0;
    if (a && car_ok) clr[cf] = 1'b1;
    if (e) begin
      n_pend = '0; n_offer = 0; n_enroute = 0; n_emerg = 1;
    end else if (m_emerg) begin
      n_pend = '0; n_emerg = 0;
    end else begin
      n_pend = (m_pend | c) & ~clr;
      if (m_offer) begin
        if (r) begin n_offer = 0; n_enroute = 1; n_served = 0; end
      end else if (m_enroute) begin
        n_served = m_served + 1;
        if (a && cf == m_tf) n_enroute = 0;
        else if (n_served == TMO) begin n_enroute = 0; n_fault = 1; end
      end else if (car_ok) begin
        pick(m_pend, cf, m_up, ok, fl, dir);
        if (ok) begin n_offer = 1; n_tf = fl; n_up = dir; end
      end
    end
    if (!car_ok) n_fault = 1;
    @(posedge CLK);
    #1;
    m_pend = n_pend; m_tf = n_tf; m_offer = n_offer; m_enroute = n_enroute;
    m_served = n_served; m_up = n_up; m_emerg = n_emerg; m_fault = n_fault;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b1; call_floor = '0; emergency_button = 0; car_floor = 4'd1;
    arrived = 0; target_ready = 0;
    #1;
    model_reset();
    check("rst_pending", pending, 0);
    check("rst_target_valid", target_valid, 0);
    check("rst_target_floor", target_floor, 1);
    check("rst_sweep_up", sweep_up, 1);
    check("rst_emergency_active", emergency_active, 0);
    check("rst_fault", fault, 0);
    @(negedge CLK);
    reset = 1'b0;
  endtask

  task automatic wait_offer(input int car);
    for (int i = 0; i < 12 && !target_valid; i++) step('0, 0, car, 0, 0);
    check("offer_wait", target_valid, 1);
  endtask

  // Accept the current offer, then report arrival there; returns the floor and direction offered.
  task automatic serve(input int car, output int fl, output bit up);
    wait_offer(car);
    fl = int'(target_floor);
    up = sweep_up;
    step('0, 0, car, 0, 1);
    step('0, 0, fl, 1, 0);
  endtask

  initial begin
    int  fl;
    bit  up;
    int  car_pos;
    int  em_hold;
    bit [8:1] c;
    bit  e, a, r;

    do_reset();

    // Single call, ready high.
    step(8'b0001_0000, 0, 1, 0, 1);
    step('0, 0, 1, 0, 1);
    check("single_valid", target_valid, 1);
    check("single_floor", target_floor, 5);
    check("single_up", sweep_up, 1);
    step('0, 0, 1, 0, 1);
    step('0, 0, 5, 1, 1);
    check("single_pending", pending, 0);
    step('0, 0, 5, 0, 1);
    check("single_idle", target_valid, 0);

    // SCAN order from floor 4 going up.
    step(8'b1010_0010, 0, 4, 0, 0);
    serve(4, fl, up);
    check("scan_first", fl, 6);
    serve(6, fl, up);
    check("scan_second", fl, 8);
    serve(8, fl, up);
    check("scan_third", fl, 2);
    check("scan_flip", up, 0);

    // Handshake hold while a new call arrives.
    step(8'b0001_0000, 0, 2, 0, 0);
    wait_offer(2);
    check("hold_initial", target_floor, 5);
    for (int i = 0; i < 10; i++) begin
      step((i == 3) ? 8'b0000_0100 : 8'b0, 0, 2, 0, 0);
      check("hold_floor", target_floor, 5);
    end
    check("hold_pending3", pending[3], 1);
    serve(2, fl, up);
    check("hold_served", fl, 5);
    serve(5, fl, up);
    check("hold_next", fl, 3);

    // Arrival and call at the same floor, then a call at the car's floor.
    step(8'b0010_0000, 0, 6, 1, 0);
    check("same_cycle_clear", pending[6], 0);
    step(8'b0010_0000, 0, 6, 0, 0);
    step('0, 0, 6, 0, 0);
    check("here_valid", target_valid, 1);
    check("here_floor", target_floor, 6);
    serve(6, fl, up);

    // Emergency during SERVING.
    step(8'b1000_0010, 0, 5, 0, 0);
    wait_offer(5);
    step('0, 0, 5, 0, 1);
    check("emerg_pre_pending", pending, 8'b1000_0010);
    step('0, 1, 5, 0, 0);
    check("emerg_pending", pending, 0);
    check("emerg_valid", target_valid, 0);
    check("emerg_active", emergency_active, 1);
    step('0, 1, 5, 0, 0);
    step('0, 0, 5, 0, 0);
    check("emerg_release", emergency_active, 0);
    step(8'b0000_0100, 0, 5, 0, 0);
    serve(5, fl, up);
    check("emerg_after", fl, 3);

    // Randomized traffic with a simple car that walks toward its accepted target.
    car_pos = 3;
    em_hold = 0;
    for (int n = 0; n < 1500; n++) begin
      c = '0;
      if ($urandom_range(0, 4) == 0) c[$urandom_range(1, 8)] = 1'b1;
      e = 0;
      if (em_hold > 0) begin e = 1; em_hold--; end
      else if ($urandom_range(0, 149) == 0) em_hold = $urandom_range(1, 4);
      r = ($urandom_range(0, 2) != 0);
      a = 0;
      if (m_enroute) begin
        if (car_pos == m_tf) a = ($urandom_range(0, 1) == 0);
        else if (m_pend[car_pos] && $urandom_range(0, 5) == 0) a = 1;
        else if ($urandom_range(0, 3) != 0) car_pos += (m_tf > car_pos) ? 1 : -1;
      end else if (m_pend[car_pos] && $urandom_range(0, 7) == 0) begin
        a = 1;
      end
      step(c, e, car_pos, a, r);
    end

    // Serving timeout.
    do_reset();
    step(8'b0000_1000, 0, 1, 0, 0);
    wait_offer(1);
    step('0, 0, 1, 0, 1);
    for (int i = 0; i < TMO - 1; i++) step('0, 0, 1, 0, 0);
    check("tmo_not_yet", fault, 0);
    step('0, 0, 1, 0, 0);
    check("tmo_fault", fault, 1);
    check("tmo_valid", target_valid, 0);
    check("tmo_pending4", pending[4], 1);
    step('0, 0, 1, 0, 0);

    // Invalid car floor.
    do_reset();
    step(8'b0000_0100, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step('0, 0, 0, 0, 1);
    check("inv_fault", fault, 1);
    check("inv_no_dispatch", target_valid, 0);
    check("inv_pending3", pending[3], 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
